warp_pc_table: RTL and testbench
================================

# warp_pc_table

Per-warp program-counter table for the fetch front end. Holds one PC per hardware warp, applies warp start/finish and the ALU/SIMT/decode redirect and replay requests, and round-robin selects one eligible warp per cycle to fetch, emitting a registered (warp id, PC) pair to instruction fetch. It generalises the single-PC update path to NUM_WARPS contexts with per-warp replay and per-warp activity tracking.

## Interface
- NUM_WARPS, 8, number of warp contexts (power of two, ≥2)
- PC_W, 32, PC width in bits
- PC_INC, 4, bytes added to a warp PC per fetch
- WID_W (localparam), $clog2(NUM_WARPS), warp id width

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start_vld / start_wid / start_pc  in  1 / WID_W / PC_W  task manager launches warp at start_pc
- done_vld / done_wid  in  1 / WID_W  warp finished; deactivate
- alu_redir_vld / alu_redir_wid / alu_redir_pc  in  1 / WID_W / PC_W  resolved branch target
- simt_redir_vld / simt_redir_wid / simt_redir_pc  in  1 / WID_W / PC_W  SIMT-stack reconvergence target
- id_redir_vld / id_redir_wid / id_redir_pc  in  1 / WID_W / PC_W  decode-time jump target
- replay_vld / replay_wid  in  1 / WID_W  rewind warp to its last fetched PC (IBuffer full / stall)
- warp_eligible  in  NUM_WARPS  per-warp fetch permission from IBuffer/scoreboard
- fetch_rdy  in  1  IF accepts a request this cycle
- fetch_vld  out  1  registered fetch request
- fetch_wid  out  WID_W  warp of the request
- fetch_pc  out  PC_W  PC to fetch
- warp_active  out  NUM_WARPS  registered per-warp active mask

## Operation
- State per warp w: pc[w], last_pc[w], active[w]; global rr_ptr (WID_W bits).
- Per-warp update priority within a cycle (highest first): start > done > ALU > SIMT > ID > replay > fetch increment. Only the winner affects warp w.
- start: active←1, pc←start_pc, last_pc←start_pc. Applies even if already active.
- done: active←0; pc/last_pc retained.
- ALU/SIMT/ID redirect: pc←target; last_pc unchanged. Ignored if warp inactive.
- replay: pc←last_pc. Ignored if warp inactive.
- Different sources naming different warps in one cycle all apply independently.
- Fetch candidate set C = active & warp_eligible & ~touched, where touched[w]=1 if any start/done/redirect/replay names w this cycle.
- If fetch_rdy and C≠0: grant g = first set bit of C searching upward from rr_ptr, wrapping at NUM_WARPS−1→0. At edge: last_pc[g]←pc[g]; pc[g]←pc[g]+PC_INC (mod 2^PC_W); fetch_vld←1, fetch_wid←g, fetch_pc←pc[g]; rr_ptr←(g+1) mod NUM_WARPS.
- Otherwise fetch_vld←0; fetch_wid/fetch_pc hold; rr_ptr holds.
- PC arithmetic wraps silently; no alignment checks.

## Timing
- Reset (rst_n=0 at edge): all pc/last_pc=0, warp_active=0, rr_ptr=0, fetch_vld=0, fetch_wid=0, fetch_pc=0. Reset overrides all inputs, including mid-operation.
- All outputs registered; one-cycle latency from grant decision to fetch_vld.
- Update in cycle N visible in pc at N+1; that warp is earliest fetchable at N+1, its fetch_pc appears at N+2.
- A warp touched in cycle N is not granted in N; the increment never races a redirect.
- fetch_vld is a single-cycle pulse per grant; no hold/backpressure beyond fetch_rdy sampled in the decision cycle.
- Back-to-back grants to the same warp allowed when it is the only candidate (PC advances PC_INC each cycle).

## Test plan
- Reset then start warp 3 at 0x100, all eligible, fetch_rdy=1 -> fetch_pc 0x100, 0x104, 0x108 for wid 3 on consecutive cycles; warp_active=0x08.
- Start warps 0,1,2 at 0x000/0x200/0x400 -> grants rotate wid 0,1,2,0… with PCs 0x000,0x200,0x400,0x004.
- Warp 1 fetched 0x200 then replay_vld wid 1 -> warp 1 not granted that cycle; next warp-1 fetch_pc = 0x200.
- Same cycle ALU redirect wid 2→0x800, ID redirect wid 2→0x900, SIMT redirect wid 0→0x40 -> next fetches: warp 2 at 0x800, warp 0 at 0x40.
- done_vld wid 0 with start_vld wid 0 at 0x10 same cycle -> warp 0 stays active, fetches 0x10; redirect to inactive warp 5 -> no effect, never granted.
- Single warp at 0xFFFF_FFFC fetched -> fetch_pc 0xFFFF_FFFC then 0x0000_0000; rst_n low mid-stream -> fetch_vld=0, warp_active=0 next cycle.

Source files
------------

// File: rtl/warp_pc_table.sv
// Per-warp program-counter table: applies start/done/redirect/replay updates
// and round-robin grants one eligible warp per cycle to instruction fetch.
module warp_pc_table #(
  parameter int NUM_WARPS = 8,
  parameter int PC_W      = 32,
  parameter int PC_INC    = 4,
  localparam int WID_W    = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_vld,
  input  logic [WID_W-1:0]     start_wid,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 done_vld,
  input  logic [WID_W-1:0]     done_wid,
  input  logic                 alu_redir_vld,
  input  logic [WID_W-1:0]     alu_redir_wid,
  input  logic [PC_W-1:0]      alu_redir_pc,
  input  logic                 simt_redir_vld,
  input  logic [WID_W-1:0]     simt_redir_wid,
  input  logic [PC_W-1:0]      simt_redir_pc,
  input  logic                 id_redir_vld,
  input  logic [WID_W-1:0]     id_redir_wid,
  input  logic [PC_W-1:0]      id_redir_pc,
  input  logic                 replay_vld,
  input  logic [WID_W-1:0]     replay_wid,
  input  logic [NUM_WARPS-1:0] warp_eligible,
  input  logic                 fetch_rdy,
  output logic                 fetch_vld,
  output logic [WID_W-1:0]     fetch_wid,
  output logic [PC_W-1:0]      fetch_pc,
  output logic [NUM_WARPS-1:0] warp_active
);

  logic [PC_W-1:0]      pc      [NUM_WARPS];
  logic [PC_W-1:0]      last_pc [NUM_WARPS];
  logic [NUM_WARPS-1:0] active;
  logic [WID_W-1:0]     rr_ptr;

  logic [NUM_WARPS-1:0] start_hit, done_hit, alu_hit, simt_hit, id_hit, replay_hit;
  logic [NUM_WARPS-1:0] touched, cand;
  logic                 found, grant_vld;
  logic [WID_W-1:0]     grant_wid, idx;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      start_hit[w]  = start_vld      && (start_wid      == WID_W'(w));
      done_hit[w]   = done_vld       && (done_wid       == WID_W'(w));
      alu_hit[w]    = alu_redir_vld  && (alu_redir_wid  == WID_W'(w));
      simt_hit[w]   = simt_redir_vld && (simt_redir_wid == WID_W'(w));
      id_hit[w]     = id_redir_vld   && (id_redir_wid   == WID_W'(w));
      replay_hit[w] = replay_vld     && (replay_wid     == WID_W'(w));
    end
    // A warp updated this cycle must not also take the fetch increment.
    touched = start_hit | done_hit | alu_hit | simt_hit | id_hit | replay_hit;
    cand    = active & warp_eligible & ~touched;
  end

  always_comb begin
    found     = 1'b0;
    grant_wid = '0;
    idx       = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_ptr + WID_W'(i);
      if (!found && cand[idx]) begin
        found     = 1'b1;
        grant_wid = idx;
      end
    end
    grant_vld = found && fetch_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc[w]      <= '0;
        last_pc[w] <= '0;
      end
      active    <= '0;
      rr_ptr    <= '0;
      fetch_vld <= 1'b0;
      fetch_wid <= '0;
      fetch_pc  <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (start_hit[w]) begin
          active[w]  <= 1'b1;
          pc[w]      <= start_pc;
          last_pc[w] <= start_pc;
        end else if (done_hit[w]) begin
          active[w] <= 1'b0;
        end else if (alu_hit[w]) begin
          if (active[w]) pc[w] <= alu_redir_pc;
        end else if (simt_hit[w]) begin
          if (active[w]) pc[w] <= simt_redir_pc;
        end else if (id_hit[w]) begin
          if (active[w]) pc[w] <= id_redir_pc;
        end else if (replay_hit[w]) begin
          if (active[w]) pc[w] <= last_pc[w];
        end else if (grant_vld && (grant_wid == WID_W'(w))) begin
          last_pc[w] <= pc[w];
          pc[w]      <= pc[w] + PC_W'(PC_INC);
        end
      end
      fetch_vld <= grant_vld;
      if (grant_vld) begin
        fetch_wid <= grant_wid;
        fetch_pc  <= pc[grant_wid];
        rr_ptr    <= grant_wid + WID_W'(1);
      end
    end
  end

  assign warp_active = active;

endmodule

// File: tb/tb_warp_pc_table.sv
// Directed bench for warp_pc_table: expected fetches are queued by the stimulus
// and popped by an independent monitor whenever fetch_vld is seen.
module tb_warp_pc_table;
  localparam int NW = 8;
  localparam int PW = 32;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_vld, done_vld, alu_redir_vld, simt_redir_vld, id_redir_vld, replay_vld;
  logic [WW-1:0] start_wid, done_wid, alu_redir_wid, simt_redir_wid, id_redir_wid, replay_wid;
  logic [PW-1:0] start_pc, alu_redir_pc, simt_redir_pc, id_redir_pc;
  logic [NW-1:0] warp_eligible;
  logic          fetch_rdy;
  logic          fetch_vld;
  logic [WW-1:0] fetch_wid;
  logic [PW-1:0] fetch_pc;
  logic [NW-1:0] warp_active;

  int n_cmp = 0;
  int n_err = 0;
  logic [WW-1:0] exp_wid [$];
  logic [PW-1:0] exp_pc  [$];

  warp_pc_table #(.NUM_WARPS(NW), .PC_W(PW), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_vld(start_vld), .start_wid(start_wid), .start_pc(start_pc),
    .done_vld(done_vld), .done_wid(done_wid),
    .alu_redir_vld(alu_redir_vld), .alu_redir_wid(alu_redir_wid), .alu_redir_pc(alu_redir_pc),
    .simt_redir_vld(simt_redir_vld), .simt_redir_wid(simt_redir_wid), .simt_redir_pc(simt_redir_pc),
    .id_redir_vld(id_redir_vld), .id_redir_wid(id_redir_wid), .id_redir_pc(id_redir_pc),
    .replay_vld(replay_vld), .replay_wid(replay_wid),
    .warp_eligible(warp_eligible), .fetch_rdy(fetch_rdy),
    .fetch_vld(fetch_vld), .fetch_wid(fetch_wid), .fetch_pc(fetch_pc),
    .warp_active(warp_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Monitor: every fetch pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (fetch_vld) begin
      n_cmp++;
      if (exp_wid.size() == 0) begin
        n_err++;
        $display("FAIL fetch_unexpected: got wid=%0d pc=%h, none expected", fetch_wid, fetch_pc);
      end else begin
        logic [WW-1:0] w;
        logic [PW-1:0] p;
        w = exp_wid.pop_front();
        p = exp_pc.pop_front();
        if (fetch_wid !== w || fetch_pc !== p) begin
          n_err++;
          $display("FAIL fetch: got wid=%0d pc=%h, expected wid=%0d pc=%h", fetch_wid, fetch_pc, w, p);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_fetch(input logic [WW-1:0] w, input logic [PW-1:0] p);
    exp_wid.push_back(w);
    exp_pc.push_back(p);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    start_vld = 0; done_vld = 0; alu_redir_vld = 0; simt_redir_vld = 0;
    id_redir_vld = 0; replay_vld = 0;
  endtask

  task automatic do_start(input logic [WW-1:0] w, input logic [PW-1:0] p);
    start_vld = 1; start_wid = w; start_pc = p;
  endtask

  initial begin
    rst_n = 0;
    clear_ctl();
    start_wid = 0; done_wid = 0; alu_redir_wid = 0; simt_redir_wid = 0;
    id_redir_wid = 0; replay_wid = 0;
    start_pc = 0; alu_redir_pc = 0; simt_redir_pc = 0; id_redir_pc = 0;
    warp_eligible = '1;
    fetch_rdy = 1;
    tick(2);
    @(negedge clk);
    check("rst_fetch_vld", 64'(fetch_vld), 64'd0);
    check("rst_warp_active", 64'(warp_active), 64'h00);
    check("rst_fetch_pc", 64'(fetch_pc), 64'h0);
    check("rst_fetch_wid", 64'(fetch_wid), 64'h0);
    rst_n = 1;

    // Single warp 3 at 0x100, fetching back to back.
    do_start(3, 32'h100);
    tick(1);
    clear_ctl();
    expect_fetch(3, 32'h100); expect_fetch(3, 32'h104); expect_fetch(3, 32'h108);
    tick(3);
    fetch_rdy = 0;
    @(negedge clk);
    check("active_w3", 64'(warp_active), 64'h08);

    // Warps 0,1,2 launched while warp 3 retires; rr_ptr is 4 here.
    tick(1);
    do_start(0, 32'h000); done_vld = 1; done_wid = 3;
    tick(1);
    clear_ctl(); do_start(1, 32'h200);
    tick(1);
    clear_ctl(); do_start(2, 32'h400);
    tick(1);
    clear_ctl();
    @(negedge clk);
    check("active_w012", 64'(warp_active), 64'h07);
    tick(1);
    fetch_rdy = 1;
    expect_fetch(0, 32'h000); expect_fetch(1, 32'h200);
    expect_fetch(2, 32'h400); expect_fetch(0, 32'h004);
    tick(4);

    // Replay warp 1 (last fetched 0x200): it is skipped that cycle, then refetches 0x200.
    replay_vld = 1; replay_wid = 1;
    expect_fetch(2, 32'h404);
    tick(1);
    clear_ctl();
    expect_fetch(0, 32'h008); expect_fetch(1, 32'h200);
    tick(2);

    // Same-cycle redirects: ALU beats ID on warp 2, SIMT on warp 0; only warp 1 fetchable.
    alu_redir_vld = 1; alu_redir_wid = 2; alu_redir_pc = 32'h800;
    id_redir_vld = 1; id_redir_wid = 2; id_redir_pc = 32'h900;
    simt_redir_vld = 1; simt_redir_wid = 0; simt_redir_pc = 32'h40;
    expect_fetch(1, 32'h204);
    tick(1);
    clear_ctl();
    expect_fetch(2, 32'h800); expect_fetch(0, 32'h040);
    tick(2);
    fetch_rdy = 0;

    // done+start on warp 0 together; redirect to inactive warp 5 has no effect.
    done_vld = 1; done_wid = 0; do_start(0, 32'h10);
    alu_redir_vld = 1; alu_redir_wid = 5; alu_redir_pc = 32'h500;
    tick(1);
    clear_ctl();
    @(negedge clk);
    check("active_after_done_start", 64'(warp_active), 64'h07);
    tick(1);
    fetch_rdy = 1;
    expect_fetch(1, 32'h208); expect_fetch(2, 32'h804);
    expect_fetch(0, 32'h010); expect_fetch(1, 32'h20c);
    tick(4);
    fetch_rdy = 0;
    @(negedge clk);
    check("active_no_w5", 64'(warp_active), 64'h07);

    // Eligibility mask: only warp 2 eligible.
    tick(1);
    warp_eligible = 8'h04; fetch_rdy = 1;
    expect_fetch(2, 32'h808); expect_fetch(2, 32'h80c);
    tick(2);
    fetch_rdy = 0; warp_eligible = '1;

    // Single warp 6 across the PC wrap, then reset mid-stream.
    done_vld = 1; done_wid = 0; do_start(6, 32'hFFFF_FFFC);
    tick(1);
    clear_ctl(); done_vld = 1; done_wid = 1;
    tick(1);
    clear_ctl(); done_vld = 1; done_wid = 2;
    tick(1);
    clear_ctl();
    @(negedge clk);
    check("active_w6", 64'(warp_active), 64'h40);
    tick(1);
    fetch_rdy = 1;
    expect_fetch(6, 32'hFFFF_FFFC); expect_fetch(6, 32'h0000_0000);
    tick(2);
    rst_n = 0;
    tick(1);
    @(negedge clk);
    check("midrst_fetch_vld", 64'(fetch_vld), 64'd0);
    check("midrst_warp_active", 64'(warp_active), 64'h00);
    check("midrst_fetch_pc", 64'(fetch_pc), 64'h0);
    tick(1);
    rst_n = 1;
    tick(4);
    fetch_rdy = 0;
    tick(2);
    check("pending_expected", 64'(exp_wid.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
